// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg: shared select encodings, register constants and shadow-stage types
// Package mips_ctrl_pkg
//   FWD_*     EX operand mux select encodings
//   REG_ZERO  hard-wired zero register index
//   idex_t    ID/EX shadow stage; wb_t  EX/MEM and MEM/WB shadow stages
package mips_ctrl_pkg;
    localparam int REG_BITS = 5;
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [REG_BITS-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        logic                uses_rs;
        logic                uses_rt;
        logic [REG_BITS-1:0] dest;
        logic                reg_write;
        logic                mem_read;
    } idex_t;
    typedef struct packed {
        logic [REG_BITS-1:0] dest;
        logic                reg_write;
    } wb_t;
endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// fwd_select: per-operand forwarding priority comparator (EX/MEM over MEM/WB, never $0)
// Ports: src/uses  operand register index and whether it is read
//        exmem_*   EX/MEM destination and write enable
//        memwb_*   MEM/WB destination and write enable
//        sel       operand mux select
module fwd_select
    import mips_ctrl_pkg::*;
#(
    parameter int REG_W = REG_BITS
) (
    input  logic [REG_W-1:0] src,
    input  logic             uses,
    input  logic [REG_W-1:0] exmem_dest,
    input  logic             exmem_we,
    input  logic [REG_W-1:0] memwb_dest,
    input  logic             memwb_we,
    output logic [1:0]       sel
);
    logic hit_exmem;
    logic hit_memwb;
    assign hit_exmem = uses & exmem_we & (exmem_dest != REG_W'(REG_ZERO)) & (exmem_dest == src);
    assign hit_memwb = uses & memwb_we & (memwb_dest != REG_W'(REG_ZERO)) & (memwb_dest == src);
    assign sel = hit_exmem ? FWD_EXMEM : hit_memwb ? FWD_MEMWB : FWD_REGFILE;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: forwarding selects, load-use stall, branch flush and perf counters for a 5-stage MIPS pipe
// Ports: id_*            decode-stage operand/destination/control info
//        ex_branch_taken branch resolved taken in EX
//        fwd_a/fwd_b     EX operand mux selects
//        pc_write/ifid_write/ifid_flush/idex_bubble  pipeline controls
//        stall_count/flush_count  load-use stall and branch flush cycle counters
module hazard_forward_unit
    import mips_ctrl_pkg::*;
#(
    parameter int REG_W = REG_BITS,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    idex_t idex;
    idex_t idex_next;
    wb_t   exmem;
    wb_t   memwb;
    logic  load_use;

    // Only a load in EX can't be covered by forwarding; one bubble lets MEM/WB supply it.
    assign load_use = idex.mem_read & (idex.dest != REG_ZERO) &
                      (((idex.dest == id_rs) & id_uses_rs) | ((idex.dest == id_rt) & id_uses_rt));

    // A taken branch discards the ID instruction, so it overrides a pending stall.
    assign ifid_flush  = ex_branch_taken;
    assign idex_bubble = ex_branch_taken | load_use;
    assign pc_write    = ex_branch_taken | ~load_use;
    assign ifid_write  = ex_branch_taken | ~load_use;

    assign idex_next = idex_bubble ? '0 : '{rs: id_rs, rt: id_rt, uses_rs: id_uses_rs, uses_rt: id_uses_rt,
                                            dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex        <= '0;
            exmem       <= '0;
            memwb       <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            idex        <= idex_next;
            exmem       <= '{dest: idex.dest, reg_write: idex.reg_write};
            memwb       <= exmem;
            stall_count <= stall_count + CNT_W'(load_use & ~ex_branch_taken);
            flush_count <= flush_count + CNT_W'(ex_branch_taken);
        end
    end

    fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .src(idex.rs), .uses(idex.uses_rs),
        .exmem_dest(exmem.dest), .exmem_we(exmem.reg_write),
        .memwb_dest(memwb.dest), .memwb_we(memwb.reg_write),
        .sel(fwd_a)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .src(idex.rt), .uses(idex.uses_rt),
        .exmem_dest(exmem.dest), .exmem_we(exmem.reg_write),
        .memwb_dest(memwb.dest), .memwb_we(memwb.reg_write),
        .sel(fwd_b)
    );
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: scoreboard bench against an instruction-history model of the pipeline
module tb_hazard_forward_unit;
    logic        clk = 0;
    logic        rst = 1;
    logic [4:0]  id_rs = 0, id_rt = 0, id_dest = 0;
    logic        id_uses_rs = 0, id_uses_rt = 0, id_reg_write = 0, id_mem_read = 0;
    logic        ex_branch_taken = 0;
    logic [1:0]  fwd_a, fwd_b;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [31:0] stall_count, flush_count;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs, rt, dest;
        bit urs, urt, we, ld;
    } ins_t;

    typedef struct {
        int fa, fb, pc, ifw, fl, bub, sc, fc;
    } exp_t;

    ins_t pipe[3];   // instructions currently in EX, MEM, WB (index 0 = EX)
    exp_t q[$];
    int   scnt = 0, fcnt = 0;
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Operand source: the youngest older instruction (MEM stage first, then WB) writing X wins.
    function automatic int model_sel(input int x, input bit uses);
        if (!uses) return 0;
        for (int d = 1; d <= 2; d++)
            if (pipe[d].we && pipe[d].dest != 0 && pipe[d].dest == x) return d == 1 ? 2 : 1;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        scnt = 0;
        fcnt = 0;
    endfunction

    task automatic step(input int rs, input int rt, input bit urs, input bit urt,
                        input int dest, input bit we, input bit ld, input bit br);
        exp_t e;
        ins_t id;
        bit   lu;
        @(negedge clk);
        id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
        id_dest = 5'(dest); id_reg_write = we; id_mem_read = ld; ex_branch_taken = br;
        id = '{rs: rs, rt: rt, dest: dest, urs: urs, urt: urt, we: we, ld: ld};
        lu = pipe[0].ld && pipe[0].dest != 0 &&
             ((pipe[0].dest == rs && urs) || (pipe[0].dest == rt && urt));
        e.fa = model_sel(pipe[0].rs, pipe[0].urs);
        e.fb = model_sel(pipe[0].rt, pipe[0].urt);
        e.pc = (br || !lu) ? 1 : 0;
        e.ifw = e.pc;
        e.fl = br ? 1 : 0;
        e.bub = (br || lu) ? 1 : 0;
        e.sc = scnt;
        e.fc = fcnt;
        q.push_back(e);
        if (br) fcnt++;
        else if (lu) scnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (br || lu) ? '{default: 0} : id;
    endtask

    task automatic alu(input int d, input int s, input int t);
        step(s, t, 1, 1, d, 1, 0, 0);
    endtask
    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic lw(input int d, input int base);
        step(base, 0, 1, 0, d, 1, 1, 0);
    endtask

    // Monitor: the DUT presents a fresh response every cycle; compare it mid low phase.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("fwd_a", int'(fwd_a), e.fa);
                chk("fwd_b", int'(fwd_b), e.fb);
                chk("pc_write", int'(pc_write), e.pc);
                chk("ifid_write", int'(ifid_write), e.ifw);
                chk("ifid_flush", int'(ifid_flush), e.fl);
                chk("idex_bubble", int'(idex_bubble), e.bub);
                chk("stall_count", int'(stall_count), e.sc);
                chk("flush_count", int'(flush_count), e.fc);
            end
        end
    end

    initial begin
        model_reset();
        #12;
        chk("reset_fwd_a", int'(fwd_a), 0);
        chk("reset_pc_write", int'(pc_write), 1);
        chk("reset_idex_bubble", int'(idex_bubble), 0);
        chk("reset_stall_count", int'(stall_count), 0);
        @(negedge clk);
        rst = 0;
        // back-to-back ALU dependency
        alu(3, 1, 2); step(3, 5, 1, 1, 4, 1, 0, 0); nop(); nop(); nop();
        // distance-2 dependency
        alu(3, 1, 2); nop(); alu(6, 3, 3); nop(); nop(); nop();
        // double hazard
        alu(3, 1, 2); alu(3, 4, 5); alu(7, 3, 3); nop(); nop(); nop();
        // load-use
        lw(8, 9); alu(10, 8, 8); alu(10, 8, 8); nop(); nop(); nop();
        // $0 guard
        alu(0, 1, 2); alu(0, 1, 2); alu(5, 0, 0); nop(); nop(); nop();
        lw(0, 9); alu(5, 0, 0); nop(); nop();
        // branch in same cycle as load-use
        lw(8, 9); step(8, 8, 1, 1, 10, 1, 0, 1); nop(); nop(); nop();
        // asynchronous reset mid-stall
        lw(8, 9); alu(10, 8, 8);
        #3;
        id_uses_rs = 0; id_uses_rt = 0; id_mem_read = 0; id_reg_write = 0;
        rst = 1;
        #1;
        chk("arst_fwd_a", int'(fwd_a), 0);
        chk("arst_fwd_b", int'(fwd_b), 0);
        chk("arst_pc_write", int'(pc_write), 1);
        chk("arst_idex_bubble", int'(idex_bubble), 0);
        chk("arst_stall_count", int'(stall_count), 0);
        chk("arst_flush_count", int'(flush_count), 0);
        rst = 0;
        model_reset();
        // randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            bit ld, br;
            ld = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3), ld | 1'($urandom), ld, br);
        end
        nop(); nop();
        begin
            int budget = 10;
            while (q.size() != 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            #3;
            if (q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL drain got %0d pending expected 0", q.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Control-side counterpart to the datapath select muxes: it generates the select lines (fwd_a/fwd_b for the 3-input 32-bit EX operand muxes) and the stall/flush controls consumed by the 5-stage MIPS pipeline.
- Keeps its own shadow pipeline of destination-register and control bits (ID/EX, EX/MEM, MEM/WB), so the datapath only presents decode-stage information.
- Also counts stall and flush cycles for performance debug.

Parameters:
- REG_W, 5, register-index width
- CNT_W, 32, width of the stall/flush performance counters

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- id_rs  in  REG_W  rs field of the instruction in ID
- id_rt  in  REG_W  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_dest  in  REG_W  destination after the RegDst 5-bit mux
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- fwd_a  out  2  EX operand-A select: 00 regfile, 01 MEM/WB result, 10 EX/MEM result
- fwd_b  out  2  EX operand-B select, same encoding
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  zero the IF/ID register
- idex_bubble  out  1  load a NOP into ID/EX
- stall_count  out  CNT_W  number of load-use stall cycles since reset
- flush_count  out  CNT_W  number of branch flush cycles since reset

Behaviour:
- Shadow stages:
  - ID/EX holds {rs, rt, uses_rs, uses_rt, dest, reg_write, mem_read}.
  - EX/MEM and MEM/WB each hold {dest, reg_write}.
  - All stages advance every cycle; the unit never freezes EX/MEM or MEM/WB.
- ID/EX load:
  - Loads the ID inputs when idex_bubble=0.
  - Loads all-zero (NOP) when idex_bubble=1.
- Forwarding (combinational from shadow regs), evaluated per operand X in {rs, rt} of ID/EX:
  - Select 10 if EX/MEM.reg_write, EX/MEM.dest!=0, EX/MEM.dest==X and uses_X.
  - Else select 01 if the same conditions hold for MEM/WB.
  - Else select 00.
  - EX/MEM has priority over MEM/WB; register $0 is never forwarded.
  - Selects are never 11.
- Register file writes in the first half-cycle, so ID needs no WB forwarding.
- Load-use detection, combinational: load_use = ID/EX.mem_read & ID/EX.dest!=0 & ((dest==id_rs & id_uses_rs) | (dest==id_rt & id_uses_rt)). The MEM/WB path covers the second cycle, so a load-use costs exactly one stall.
- Control outputs:
  - ex_branch_taken=1: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. Flush wins over load_use, because the stalled ID instruction is discarded anyway.
  - Else load_use=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - Else: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Counters:
  - stall_count increments on each posedge where load_use & !ex_branch_taken.
  - flush_count increments on each posedge where ex_branch_taken.
  - Both wrap modulo 2^CNT_W.
- Reset (asynchronous, any time including mid-stall):
  - All shadow stages clear to NOP and both counters clear to 0.
  - Outputs therefore read fwd_a=fwd_b=00, pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0. The output values hold only while ID inputs are idle (no load-use pattern), since pc_write/ifid_write/ifid_flush/idex_bubble are combinational from ID inputs and ex_branch_taken.
  - First instruction after reset release sees no stale hazards.
- Latency: forward selects are valid in the same cycle the consumer occupies EX; stall/flush are valid in the same cycle the hazard is present in ID/EX.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - FWD_REGFILE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10
  - REG_ZERO=5'd0
  - shadow-stage struct typedef
- One natural sub-module: `fwd_select`, a purely combinational per-operand priority comparator, instantiated twice (operands A and B).

Test Plan:
- Back-to-back ALU dependency: add $3,$1,$2 then sub $4,$3,$5 -> fwd_a=10 on the cycle sub is in EX; fwd_b=00; stall_count stays 0.
- Distance-2 dependency with an intervening NOP: add $3,... ; nop ; or $6,$3,$3 -> fwd_a=fwd_b=01.
- Double hazard: add $3 ; add $3 ; use $3 -> fwd_a=10 (EX/MEM priority), never 01.
- Load-use: lw $8,0($9) then add $10,$8,$8 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; next cycle fwd_a=fwd_b=01; stall_count 0->1.
- $0 guard and branch priority:
  - Writes to $0 followed by a reader of $0 -> fwd=00, no stall.
  - ex_branch_taken=1 in the same cycle as load_use -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_count+1, stall_count unchanged.
- Asynchronous reset asserted mid-stall (between edges) with ID inputs idle: shadow stages and counters clear immediately, so fwd=00, pc_write=1, idex_bubble=0 and both counters read 0 before the next clock edge.
